// File: rtl/snd_mix_n.sv
// snd_mix_n: CH-channel signed audio mixer with per-channel gain, one shared MAC and W-bit saturation.
// Defining MIX_DC_BLOCK_EN adds a one-cycle DC-blocking high-pass stage on the output.
module snd_mix_n #(
   parameter int CH = 4,
   parameter int W  = 16,
   parameter int GW = 8
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  cen,
   input  logic [CH*W-1:0]       ch_in,
   input  logic                  gain_we,
   input  logic [$clog2(CH)-1:0] gain_sel,
   input  logic [GW-1:0]         gain_din,
   input  logic                  clip_clr,
   output logic [W-1:0]          snd,
   output logic                  snd_valid,
   output logic                  busy,
   output logic                  clip,
   output logic                  overrun
);
   localparam int SW = $clog2(CH);
   localparam int PW = W + GW + 1;
   localparam int AW = PW + $clog2(CH);
   localparam logic [GW-1:0] UNITY = GW'(1 << (GW - 1));
   typedef enum logic [1:0] {IDLE, MAC, DCB, SAT} state_t;
`ifdef MIX_DC_BLOCK_EN
   localparam state_t POST = DCB;
`else
   localparam state_t POST = SAT;
`endif
   state_t state, state_nx;
   logic [SW-1:0] idx;
   logic signed [W-1:0] samp [CH];
   logic [GW-1:0] gain [CH];
   logic [GW-1:0] gain_sh [CH];
   logic signed [AW-1:0] acc, acc_nx, r;
   logic signed [PW-1:0] prod;
   logic [W-1:0] x;
   logic last, ovf, clip_set;
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == IDLE ? (cen ? MAC : IDLE)
               : state == MAC  ? (last ? POST : MAC)
               : state == DCB  ? SAT : IDLE;
   end
   always_comb begin
      busy = state != IDLE;
      snd_valid = state == SAT;
   end
   // Gain is unsigned, so it is zero-extended before the signed multiply.
   always_comb begin
      last = idx == SW'(CH - 1);
      prod = PW'(samp[idx]) * PW'($signed({1'b0, gain_sh[idx]}));
      acc_nx = acc + AW'(prod);
      r = acc_nx >>> (GW - 1);
      ovf = r[AW-1:W-1] != {(AW-W+1){r[AW-1]}};
      x = ovf ? {r[AW-1], {(W-1){~r[AW-1]}}} : r[W-1:0];
   end
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         idx <= '0;
         acc <= '0;
         clip <= 1'b0;
         overrun <= 1'b0;
         for (int k = 0; k < CH; k++) begin
            gain[k] <= UNITY;
            gain_sh[k] <= UNITY;
            samp[k] <= '0;
         end
      end else begin
         clip <= clip_set | (clip & ~clip_clr);
         overrun <= (cen & busy) | (overrun & ~clip_clr);
         for (int k = 0; k < CH; k++)
            if (gain_we && gain_sel == SW'(k)) gain[k] <= gain_din;
         if (state == IDLE && cen) begin
            for (int k = 0; k < CH; k++) begin
               samp[k] <= ch_in[k*W +: W];
               gain_sh[k] <= gain[k];
            end
            acc <= '0;
            idx <= '0;
         end else if (state == MAC) begin
            acc <= acc_nx;
            idx <= idx + SW'(1);
         end
      end
`ifdef MIX_DC_BLOCK_EN
   logic signed [W-1:0] x_r, xp, yp;
   logic signed [W+1:0] f;
   logic [W-1:0] y;
   logic fovf;
   // y[n] = x[n] - x[n-1] + y[n-1] - y[n-1]/256, two guard bits cover the worst case
   always_comb begin
      f = (W+2)'(x_r) - (W+2)'(xp) + (W+2)'(yp) - (W+2)'(yp >>> 8);
      fovf = f[W+1:W-1] != {3{f[W+1]}};
      y = fovf ? {f[W+1], {(W-1){~f[W+1]}}} : f[W-1:0];
      clip_set = (state == MAC && last && ovf) || (state == DCB && fovf);
   end
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         x_r <= '0;
         xp <= '0;
         yp <= '0;
         snd <= '0;
      end else begin
         if (state == MAC && last) x_r <= x;
         if (state == DCB) begin
            snd <= y;
            xp <= x_r;
            yp <= y;
         end
      end
`else
   always_comb clip_set = state == MAC && last && ovf;
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) snd <= '0;
      else if (state == MAC && last) snd <= x;
`endif
endmodule

// File: tb/tb_snd_mix_n.sv
// tb_snd_mix_n: randomized self-checking bench for snd_mix_n against an arithmetic mixing model.
module tb_snd_mix_n;
   localparam int CH = 4, W = 16, GW = 8;
`ifdef MIX_DC_BLOCK_EN
   localparam int LAT = CH + 2;
`else
   localparam int LAT = CH + 1;
`endif
   logic clk_sys = 0, reset_n = 0, cen = 0, gain_we = 0, clip_clr = 0;
   logic [CH*W-1:0] ch_in = '0;
   logic [1:0] gain_sel = '0;
   logic [GW-1:0] gain_din = '0;
   logic [W-1:0] snd;
   logic snd_valid, busy, clip, overrun;
   int checks = 0, errors = 0;
   int smp[CH];
   int gm[CH];
   longint xp, yp;
   bit clip_m;

   always #5 clk_sys = ~clk_sys;

   snd_mix_n #(.CH(CH), .W(W), .GW(GW)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .cen(cen), .ch_in(ch_in),
      .gain_we(gain_we), .gain_sel(gain_sel), .gain_din(gain_din), .clip_clr(clip_clr),
      .snd(snd), .snd_valid(snd_valid), .busy(busy), .clip(clip), .overrun(overrun)
   );

   task automatic reset_model;
      for (int k = 0; k < CH; k++) gm[k] = 128;
      xp = 0;
      yp = 0;
      clip_m = 0;
   endtask

   // Weighted sum, floor-divided by unity gain, clamped to the W-bit signed range
   task automatic model_mix(output int e, output bit c);
      longint s, y;
      s = 0;
      c = 0;
      for (int k = 0; k < CH; k++) s += longint'(smp[k]) * longint'(gm[k]);
      s = s >>> (GW - 1);
      if (s > 32767) begin s = 32767; c = 1; end
      else if (s < -32768) begin s = -32768; c = 1; end
`ifdef MIX_DC_BLOCK_EN
      y = s - xp + yp - (yp >>> 8);
      if (y > 32767) begin y = 32767; c = 1; end
      else if (y < -32768) begin y = -32768; c = 1; end
      xp = s;
      yp = y;
      s = y;
`else
      y = 0;
`endif
      e = int'(s);
   endtask

   task automatic rand_samples;
      for (int k = 0; k < CH; k++) smp[k] = int'($urandom_range(0, 65535)) - 32768;
   endtask

   task automatic set_gain(input int k, input int g);
      @(posedge clk_sys); #1;
      gain_we = 1; gain_sel = 2'(k); gain_din = 8'(g);
      @(posedge clk_sys); #1;
      gain_we = 0;
      gm[k] = g;
   endtask

   task automatic pulse_clr;
      @(posedge clk_sys); #1; clip_clr = 1;
      @(posedge clk_sys); #1; clip_clr = 0;
      clip_m = 0;
   endtask

   task automatic start_mix;
      for (int k = 0; k < CH; k++) ch_in[k*W +: W] = W'(smp[k]);
      @(posedge clk_sys); #1; cen = 1;
      @(posedge clk_sys); #1; cen = 0;
      for (int k = 0; k < CH; k++) ch_in[k*W +: W] = W'($urandom);
   endtask

   task automatic wait_valid(input int l0, output int lat);
      lat = l0;
      while (!snd_valid && lat < 4 * LAT) begin
         @(posedge clk_sys); #1;
         lat++;
      end
   endtask

   task automatic do_mix(output int lat, output logic [W-1:0] got, output logic b1, output logic v2);
      start_mix;
      b1 = busy;
      wait_valid(1, lat);
      got = snd;
      @(posedge clk_sys); #1;
      v2 = snd_valid | busy;
   endtask

   task automatic test_reset;
      reset_n = 0;
      repeat (3) @(posedge clk_sys); #1;
      checks++; if ({snd, snd_valid, busy} !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", {snd, snd_valid, busy}); end
      checks++; if ({clip, overrun} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {clip, overrun}); end
      @(negedge clk_sys) reset_n = 1;
      reset_model;
      @(posedge clk_sys); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_default;
      int lat, e; bit c; logic [W-1:0] got; logic b1, v2;
      smp = '{4096, 512, -256, 0};
      model_mix(e, c); clip_m |= c;
      do_mix(lat, got, b1, v2);
      checks++; if (lat != LAT) begin errors++; $display("FAIL dflt_latency got %0d exp %0d", lat, LAT); end
      checks++; if (got !== W'(e)) begin errors++; $display("FAIL dflt_snd got %h exp %h", got, W'(e)); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL dflt_busy got %b exp 1", b1); end
      checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL dflt_pulse got %b exp 0", v2); end
      checks++; if (clip !== clip_m) begin errors++; $display("FAIL dflt_clip got %b exp %b", clip, clip_m); end
      repeat (3) @(posedge clk_sys); #1;
      checks++; if (snd !== got) begin errors++; $display("FAIL dflt_hold got %h exp %h", snd, got); end
   endtask

   task automatic test_saturation;
      int lat, e; bit c; logic [W-1:0] got; logic b1, v2;
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < CH; k++) smp[k] = s == 0 ? 28672 : -28672;
         model_mix(e, c); clip_m |= c;
         do_mix(lat, got, b1, v2);
         checks++; if (got !== W'(e)) begin errors++; $display("FAIL sat%0d_snd got %h exp %h", s, got, W'(e)); end
         checks++; if (clip !== clip_m) begin errors++; $display("FAIL sat%0d_clip got %b exp %b", s, clip, clip_m); end
      end
      pulse_clr;
      checks++; if (clip !== 1'b0) begin errors++; $display("FAIL sat_clr got %b exp 0", clip); end
   endtask

   task automatic test_gain;
      int lat, e; bit c; logic [W-1:0] got; logic b1, v2;
      int gl[3] = '{64, 255, 0};
      smp = '{16384, 0, 0, 0};
      for (int i = 0; i < 3; i++) begin
         set_gain(0, gl[i]);
         model_mix(e, c); clip_m |= c;
         do_mix(lat, got, b1, v2);
         checks++; if (got !== W'(e)) begin errors++; $display("FAIL gain_%0d got %h exp %h", gl[i], got, W'(e)); end
      end
      set_gain(0, 128);
   endtask

   task automatic test_overrun;
      int lat, e, nv; bit c; logic [W-1:0] got;
      rand_samples;
      model_mix(e, c); clip_m |= c;
      start_mix;
      @(posedge clk_sys); #1; cen = 1;
      @(posedge clk_sys); #1; cen = 0;
      nv = 0; got = '0;
      for (int i = 0; i < 4 * LAT; i++) begin
         if (snd_valid) begin nv++; got = snd; end
         @(posedge clk_sys); #1;
      end
      checks++; if (nv != 1) begin errors++; $display("FAIL ovr_count got %0d exp 1", nv); end
      checks++; if (got !== W'(e)) begin errors++; $display("FAIL ovr_snd got %h exp %h", got, W'(e)); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
      pulse_clr;
      checks++; if ({overrun, clip} !== 2'b00) begin errors++; $display("FAIL ovr_clr got %b exp 00", {overrun, clip}); end
      rand_samples;
      model_mix(e, c);
      start_mix;
      wait_valid(1, lat);
      got = snd;
      cen = 1; clip_clr = 1;
      @(posedge clk_sys); #1;
      cen = 0; clip_clr = 0; clip_m = 0;
      nv = 0;
      for (int i = 0; i < 3 * LAT; i++) begin
         if (snd_valid) nv++;
         @(posedge clk_sys); #1;
      end
      checks++; if (lat != LAT) begin errors++; $display("FAIL sat_cen_lat got %0d exp %0d", lat, LAT); end
      checks++; if (got !== W'(e)) begin errors++; $display("FAIL sat_cen_snd got %h exp %h", got, W'(e)); end
      checks++; if (nv != 0) begin errors++; $display("FAIL sat_cen_extra got %0d exp 0", nv); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", overrun); end
      pulse_clr;
   endtask

   task automatic test_gain_hazard;
      int lat, e; bit c; logic [W-1:0] got; logic b1, v2;
      rand_samples;
      model_mix(e, c); clip_m |= c;
      start_mix;
      gain_we = 1; gain_sel = 0; gain_din = 8'd32;
      @(posedge clk_sys); #1;
      gain_we = 0;
      gm[0] = 32;
      wait_valid(2, lat);
      got = snd;
      checks++; if (lat != LAT) begin errors++; $display("FAIL hz_lat got %0d exp %0d", lat, LAT); end
      checks++; if (got !== W'(e)) begin errors++; $display("FAIL hz_cur got %h exp %h", got, W'(e)); end
      @(posedge clk_sys); #1;
      model_mix(e, c); clip_m |= c;
      do_mix(lat, got, b1, v2);
      checks++; if (got !== W'(e)) begin errors++; $display("FAIL hz_next got %h exp %h", got, W'(e)); end
      checks++; if (clip !== clip_m) begin errors++; $display("FAIL hz_clip got %b exp %b", clip, clip_m); end
      set_gain(0, 128);
   endtask

   task automatic test_reset_mid;
      int lat, e, nv; bit c; logic [W-1:0] got; logic b1, v2;
      set_gain(2, 7);
      rand_samples;
      start_mix;
      @(posedge clk_sys); #1;
      reset_n = 0; #1;
      checks++; if (snd !== '0) begin errors++; $display("FAIL rm_snd got %h exp 0", snd); end
      checks++; if ({busy, snd_valid} !== 2'b00) begin errors++; $display("FAIL rm_busy got %b exp 00", {busy, snd_valid}); end
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys) reset_n = 1;
      reset_model;
      nv = 0;
      for (int i = 0; i < 3 * LAT; i++) begin
         @(posedge clk_sys); #1;
         if (snd_valid) nv++;
      end
      checks++; if (nv != 0) begin errors++; $display("FAIL rm_novalid got %0d exp 0", nv); end
      rand_samples;
      model_mix(e, c); clip_m |= c;
      do_mix(lat, got, b1, v2);
      checks++; if (lat != LAT) begin errors++; $display("FAIL rm_lat got %0d exp %0d", lat, LAT); end
      checks++; if (got !== W'(e)) begin errors++; $display("FAIL rm_snd2 got %h exp %h", got, W'(e)); end
   endtask

   task automatic test_random;
      int lat, e; bit c; logic [W-1:0] got; logic b1, v2;
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < CH; k++)
            if ($urandom_range(0, 3) == 0) set_gain(k, int'($urandom_range(0, 255)));
         rand_samples;
         if ($urandom_range(0, 4) == 0)
            for (int k = 0; k < CH; k++) smp[k] = (i % 2) ? 32767 : -32768;
         model_mix(e, c); clip_m |= c;
         do_mix(lat, got, b1, v2);
         checks++; if (lat != LAT) begin errors++; $display("FAIL rnd%0d_lat got %0d exp %0d", i, lat, LAT); end
         checks++; if (got !== W'(e)) begin errors++; $display("FAIL rnd%0d_snd got %h exp %h", i, got, W'(e)); end
         checks++; if (clip !== clip_m) begin errors++; $display("FAIL rnd%0d_clip got %b exp %b", i, clip, clip_m); end
         if ($urandom_range(0, 3) == 0) pulse_clr;
      end
   endtask

`ifdef MIX_DC_BLOCK_EN
   task automatic test_dc;
      int lat, e; bit c; logic [W-1:0] got, prev; logic b1, v2;
      reset_n = 0;
      @(posedge clk_sys);
      @(negedge clk_sys) reset_n = 1;
      reset_model;
      smp = '{4096, 0, 0, 0};
      prev = W'(16'h7fff);
      for (int i = 0; i < 4; i++) begin
         model_mix(e, c); clip_m |= c;
         do_mix(lat, got, b1, v2);
         checks++; if (got !== W'(e)) begin errors++; $display("FAIL dc%0d got %h exp %h", i, got, W'(e)); end
         checks++; if ($signed(got) >= $signed(prev)) begin errors++; $display("FAIL dc%0d_decay got %h prev %h", i, got, prev); end
         prev = got;
      end
   endtask
`endif

   initial begin
      test_reset;
      test_default;
      test_saturation;
      test_gain;
      test_overrun;
      test_gain_hazard;
      test_reset_mid;
      test_random;
`ifdef MIX_DC_BLOCK_EN
      test_dc;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
